mem_arbiter: RTL and testbench

Arbitrates one single-ported unified instruction/data memory between the fetch stage (I-side, read-only) and the memory stage (D-side, LW/SW).
Sits between the pipeline and the memory model.
Registers the winning request, issues a one-cycle memory command, waits for the memory's response, then returns read data and ack to the winner.
Generates the I-side and D-side stall signals, and a watchdog error if the memory never responds.

---
 rtl/arb_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/arb_watchdog.sv | 29 ++
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the unified I/D memory arbiter: FSM state encoding
// and the grant identifiers used for round-robin tie-breaking.
package arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_I = 3'd1,
        S_ISSUE_D = 3'd2,
        S_WAIT_I  = 3'd3,
        S_WAIT_D  = 3'd4
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, bundled with
// modports for the arbiter (slave) and the pipeline plus memory (master).
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Handshake: x_req is held high with stable address/data until the
    // one-cycle x_ack; mem_enable is a one-cycle command strobe and
    // mem_data_valid a one-cycle completion for both reads and writes.
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              stall_if;
    logic              stall_mem;

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    logic              err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_data_out, mem_data_valid,
        output i_ack, i_rdata, d_ack, d_rdata, stall_if, stall_mem,
        output mem_enable, mem_wr, mem_addr, mem_data_in, err
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_data_out, mem_data_valid,
        input  i_ack, i_rdata, d_ack, d_rdata, stall_if, stall_mem,
        input  mem_enable, mem_wr, mem_addr, mem_data_in, err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Response watchdog: counts WAIT cycles since the last issue and flags the
// cycle in which the count reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // The TIMEOUT-th WAIT cycle is the one where cnt still reads TIMEOUT-1.
    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Unified I/D memory arbiter: one outstanding transaction, D wins a conflict
// unless it won the previous one, registered command, watchdog on responses.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output logic [2:0]   dbg_state
);
    arb_state_e        state;
    logic              last_grant;
    logic              pick_d;
    logic              in_issue;
    logic              in_wait;
    logic              wd_expire;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] rsp_data;

    assign pick_d     = bus.d_req && (!bus.i_req || (last_grant == GRANT_I));
    assign grant_addr = pick_d ? bus.d_addr : bus.i_addr;
    assign in_issue   = (state == S_ISSUE_I) || (state == S_ISSUE_D);
    assign in_wait    = (state == S_WAIT_I) || (state == S_WAIT_D);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_issue),
        .en    (in_wait),
        .expire(wd_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            last_grant      <= GRANT_I;
            bus.mem_enable  <= 1'b0;
            bus.mem_wr      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data_in <= '0;
            bus.err         <= 1'b0;
        end else begin
            bus.mem_enable <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.d_req || bus.i_req) begin
                        state           <= pick_d ? S_ISSUE_D : S_ISSUE_I;
                        last_grant      <= pick_d ? GRANT_D : GRANT_I;
                        bus.mem_enable  <= 1'b1;
                        bus.mem_wr      <= pick_d && bus.d_wr;
                        bus.mem_addr    <= grant_addr;
                        bus.mem_data_in <= pick_d ? bus.d_wdata : '0;
                    end
                end
                S_ISSUE_I: state <= S_WAIT_I;
                S_ISSUE_D: state <= S_WAIT_D;
                S_WAIT_I, S_WAIT_D: begin
                    // A response arriving on the expiry cycle still completes normally.
                    if (bus.mem_data_valid) begin
                        state <= S_IDLE;
                    end else if (wd_expire) begin
                        state   <= S_IDLE;
                        bus.err <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rsp_data      = bus.mem_data_out;
    assign bus.i_ack     = (state == S_WAIT_I) && bus.mem_data_valid;
    assign bus.d_ack     = (state == S_WAIT_D) && bus.mem_data_valid;
    assign bus.i_rdata   = bus.i_ack ? rsp_data : '0;
    assign bus.d_rdata   = (bus.d_ack && !bus.mem_wr) ? rsp_data : '0;
    // Stalls are masked while reset is held so every output reads 0 in reset.
    assign bus.stall_if  = rst_n && bus.i_req && !bus.i_ack;
    assign bus.stall_mem = rst_n && bus.d_req && !bus.d_ack;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle
// corner sequences, and a randomized run against a transaction-level model.
module tb_mem_arbiter;
    import arb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    typedef struct {
        logic          d_side;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- memory model ----------------
    logic [DW-1:0] mem_arr [0:65535];
    int            mem_lat = 1;
    bit            mem_never = 1'b0;
    bit            mem_rand = 1'b0;
    bit            spur_valid = 1'b0;
    int            cd = 0;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = init_val(AW'(i));
        mem_arr[16'h0010] = 16'hB12F;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_data_valid = 1'b0;
            bus.mem_data_out = DW'($urandom);
            if (!rst_n) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        bus.mem_data_valid = 1'b1;
                        if (cmd_wr) mem_arr[cmd_addr] = cmd_wdata;
                        else bus.mem_data_out = mem_arr[cmd_addr];
                    end
                end
                if (spur_valid) begin
                    bus.mem_data_valid = 1'b1;
                    spur_valid = 1'b0;
                end
                if (bus.mem_enable && !mem_never) begin
                    cd = mem_rand ? $urandom_range(1, 5) : mem_lat;
                    cmd_wr = bus.mem_wr;
                    cmd_addr = bus.mem_addr;
                    cmd_wdata = bus.mem_data_in;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_ack"}, bus.i_ack, 0);
        check({tag, "_d_ack"}, bus.d_ack, 0);
        check({tag, "_i_rdata"}, bus.i_rdata, 0);
        check({tag, "_d_rdata"}, bus.d_rdata, 0);
        check({tag, "_stall_if"}, bus.stall_if, 0);
        check({tag, "_stall_mem"}, bus.stall_mem, 0);
        check({tag, "_mem_enable"}, bus.mem_enable, 0);
        check({tag, "_mem_wr"}, bus.mem_wr, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_data_in"}, bus.mem_data_in, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_state"}, dbg_state, S_IDLE);
    endtask

    // ---------------- reference model state ----------------
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ref_wr [int];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_wr.exists(int'(a)) ? ref_wr[int'(a)] : init_val(a);
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return 16'h0100 + 16'($urandom_range(0, 15));
    endfunction

    vec_t          vecs [6];
    int            ack_cyc;
    logic          ack, other, stall, got;
    logic [DW-1:0] rdata, exp_rd;
    int            ngr, nack;
    logic          side, last_side;
    logic          act_i, act_d, got_i, got_d, gen;
    logic          outst, os_d, prev_idle, prev_i, prev_d, was_out;
    logic          exp_en, exp_ia, exp_da, win_d, m_last;

    initial begin
        #1000000;
        bad++;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_wr = 1'b0;
        bus.d_addr = '0;
        bus.d_wdata = '0;

        // Reset state, with requests present so stalls are exercised too.
        repeat (3) @(negedge clk);
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        #1 check_all_zero("reset");
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();

        // Vector table: single transactions, each started from IDLE.
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 4, 16'hB12F};
        vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 2, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 1, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 16'h0200, 16'h0000, 3, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b0, 16'h0033, 16'h0000, TO, init_val(16'h0033)};
        vecs[5] = '{1'b1, 1'b1, 16'h0201, 16'h1234, 1, 16'h0000};

        for (int v = 0; v < 6; v++) begin
            mem_lat = vecs[v].lat;
            if (vecs[v].d_side) begin
                bus.d_req = 1'b1;
                bus.d_wr = vecs[v].wr;
                bus.d_addr = vecs[v].addr;
                bus.d_wdata = vecs[v].wdata;
            end else begin
                bus.i_req = 1'b1;
                bus.i_addr = vecs[v].addr;
            end
            ack_cyc = -1;
            for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
                @(negedge clk);
                ack   = vecs[v].d_side ? bus.d_ack : bus.i_ack;
                other = vecs[v].d_side ? bus.i_ack : bus.d_ack;
                stall = vecs[v].d_side ? bus.stall_mem : bus.stall_if;
                rdata = vecs[v].d_side ? bus.d_rdata : bus.i_rdata;
                check($sformatf("v%0d_c%0d_cmd_en", v, c), bus.mem_enable, (c == 1));
                if (c == 1) begin
                    check($sformatf("v%0d_cmd_addr", v), bus.mem_addr, vecs[v].addr);
                    check($sformatf("v%0d_cmd_wr", v), bus.mem_wr, vecs[v].wr);
                    if (vecs[v].wr) check($sformatf("v%0d_cmd_wdata", v), bus.mem_data_in, vecs[v].wdata);
                end
                check($sformatf("v%0d_other_ack", v), other, 0);
                check($sformatf("v%0d_err", v), bus.err, 0);
                if (ack) begin
                    ack_cyc = c;
                    check($sformatf("v%0d_rdata", v), rdata, vecs[v].exp_rdata);
                    check($sformatf("v%0d_stall_on_ack", v), stall, 0);
                end else begin
                    check($sformatf("v%0d_c%0d_stall", v, c), stall, 1);
                end
                next_cycle();
            end
            check($sformatf("v%0d_ack_cycle", v), ack_cyc, vecs[v].lat + 1);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d_idle_err", v), bus.err, 0);
            check($sformatf("v%0d_idle_state", v), dbg_state, S_IDLE);
            next_cycle();
        end

        // Response strobe while IDLE must be ignored.
        @(negedge clk);
        spur_valid = 1'b1;
        next_cycle();
        @(negedge clk);
        check("spur_valid_seen", bus.mem_data_valid, 1);
        check("spur_i_ack", bus.i_ack, 0);
        check("spur_d_ack", bus.d_ack, 0);
        check("spur_state", dbg_state, S_IDLE);
        next_cycle();
        @(negedge clk);
        check("spur_state_after", dbg_state, S_IDLE);
        check("spur_no_cmd", bus.mem_enable, 0);
        next_cycle();

        // Asynchronous reset while D waits; pending fetch is served afterwards.
        mem_never = 1'b1;
        bus.d_req = 1'b1;
        bus.d_wr = 1'b0;
        bus.d_addr = 16'h0080;
        next_cycle();
        bus.i_req = 1'b1;
        bus.i_addr = 16'h0090;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_pre_state", dbg_state, S_WAIT_D);
        check("rst_pre_stall_if", bus.stall_if, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        bus.d_req = 1'b0;
        mem_never = 1'b0;
        mem_lat = 2;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_stall_if", bus.stall_if, 1);
        @(negedge clk);
        check("rst_rel_cmd_en", bus.mem_enable, 1);
        check("rst_rel_cmd_addr", bus.mem_addr, 16'h0090);
        check("rst_rel_cmd_wr", bus.mem_wr, 0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.i_ack) begin
                got = 1'b1;
                check("rst_rel_rdata", bus.i_rdata, init_val(16'h0090));
            end
        end
        check("rst_rel_ack", got, 1);
        next_cycle();
        bus.i_req = 1'b0;

        // Both sides held continuously: grants alternate D, I, D, I ...
        mem_lat = 1;
        bus.i_req = 1'b1;
        bus.i_addr = 16'h0040;
        bus.d_req = 1'b1;
        bus.d_wr = 1'b0;
        bus.d_addr = 16'h0050;
        ngr = 0;
        nack = 0;
        last_side = 1'b0;
        for (int c = 0; c < 80 && nack < 8; c++) begin
            @(negedge clk);
            check("rr_ack_overlap", bus.i_ack && bus.d_ack, 0);
            if (bus.mem_enable) begin
                side = (bus.mem_addr == 16'h0050);
                check($sformatf("rr_grant%0d", ngr), side, (ngr % 2 == 0));
                ngr++;
                last_side = side;
            end
            if (bus.i_ack || bus.d_ack) begin
                check($sformatf("rr_ack_side%0d", nack), bus.d_ack, last_side);
                if (bus.i_ack) check("rr_i_rdata", bus.i_rdata, init_val(16'h0040));
                else check("rr_d_rdata", bus.d_rdata, init_val(16'h0050));
                nack++;
            end
        end
        check("rr_acks", nack, 8);
        check("rr_grants", ngr, 8);
        next_cycle();
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("rr_end_state", dbg_state, S_IDLE);
        next_cycle();

        // Memory silent: err after TIMEOUT WAIT cycles, then the fetch re-issues.
        mem_never = 1'b1;
        bus.i_req = 1'b1;
        bus.i_addr = 16'h0070;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("wd_c%0d_en", c), bus.mem_enable, (c == 1 || c == 11));
            check($sformatf("wd_c%0d_err", c), bus.err, (c == 10));
            check($sformatf("wd_c%0d_ack", c), bus.i_ack, 0);
            if (c == 11) check("wd_reissue_addr", bus.mem_addr, 16'h0070);
            if (c == 10) begin
                check("wd_err_state", dbg_state, S_IDLE);
                mem_never = 1'b0;
            end
        end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.i_ack) begin
                got = 1'b1;
                check("wd_retry_rdata", bus.i_rdata, init_val(16'h0070));
            end
        end
        check("wd_retry_ack", got, 1);
        next_cycle();
        bus.i_req = 1'b0;
        next_cycle();

        // Randomized traffic against the transaction-level model.
        mem_rand = 1'b1;
        m_last = GRANT_I;
        outst = 1'b0;
        os_d = 1'b0;
        prev_idle = 1'b1;
        prev_i = 1'b0;
        prev_d = 1'b0;
        act_i = 1'b0;
        act_d = 1'b0;
        got_i = 1'b0;
        got_d = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            gen = (c < 1200);
            if (got_i) begin
                got_i = 1'b0;
                if (gen && $urandom_range(0, 3) == 0) bus.i_addr = rnd_addr();
                else begin
                    act_i = 1'b0;
                    bus.i_req = 1'b0;
                end
            end else if (!act_i && gen && $urandom_range(0, 2) == 0) begin
                act_i = 1'b1;
                bus.i_req = 1'b1;
                bus.i_addr = rnd_addr();
            end
            if (got_d) begin
                got_d = 1'b0;
                if (gen && $urandom_range(0, 3) == 0) begin
                    bus.d_addr = rnd_addr();
                    bus.d_wr = 1'($urandom_range(0, 1));
                    bus.d_wdata = DW'($urandom);
                end else begin
                    act_d = 1'b0;
                    bus.d_req = 1'b0;
                end
            end else if (!act_d && gen && $urandom_range(0, 2) == 0) begin
                act_d = 1'b1;
                bus.d_req = 1'b1;
                bus.d_addr = rnd_addr();
                bus.d_wr = 1'($urandom_range(0, 1));
                bus.d_wdata = DW'($urandom);
            end

            @(negedge clk);
            was_out = outst;
            exp_en = prev_idle && (prev_i || prev_d);
            exp_ia = was_out && !os_d && bus.mem_data_valid;
            exp_da = was_out && os_d && bus.mem_data_valid;
            check("r_i_ack", bus.i_ack, exp_ia);
            check("r_d_ack", bus.d_ack, exp_da);
            check("r_stall_if", bus.stall_if, bus.i_req && !exp_ia);
            check("r_stall_mem", bus.stall_mem, bus.d_req && !exp_da);
            check("r_err", bus.err, 0);
            check("r_cmd_en", bus.mem_enable, exp_en);
            if (exp_ia || exp_da) begin
                check("r_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_rd = exp_q.pop_front();
                    check("r_rdata", exp_ia ? bus.i_rdata : bus.d_rdata, exp_rd);
                end
                outst = 1'b0;
                if (exp_ia) got_i = 1'b1;
                else got_d = 1'b1;
            end
            if (exp_en) begin
                win_d = (prev_i && prev_d) ? (m_last == GRANT_I) : prev_d;
                if (win_d) begin
                    check("r_cmd_addr_d", bus.mem_addr, bus.d_addr);
                    check("r_cmd_wr_d", bus.mem_wr, bus.d_wr);
                    if (bus.d_wr) begin
                        check("r_cmd_wdata", bus.mem_data_in, bus.d_wdata);
                        exp_q.push_back('0);
                        ref_wr[int'(bus.d_addr)] = bus.d_wdata;
                    end else begin
                        exp_q.push_back(ref_read(bus.d_addr));
                    end
                end else begin
                    check("r_cmd_addr_i", bus.mem_addr, bus.i_addr);
                    check("r_cmd_wr_i", bus.mem_wr, 0);
                    exp_q.push_back(ref_read(bus.i_addr));
                end
                outst = 1'b1;
                os_d = win_d;
                m_last = win_d ? GRANT_D : GRANT_I;
            end
            prev_idle = !was_out && !exp_en;
            prev_i = bus.i_req;
            prev_d = bus.d_req;
            next_cycle();
        end
        check("r_drain_queue", exp_q.size(), 0);
        check("r_drain_requesters", act_i || act_d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
